// File: rtl/axi4_lite_fill_arbiter_pkg.sv
// Shared types for the line-fill arbiter: FSM states and requester ids.
package axi4_lite_fill_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_e;

  typedef enum logic {
    PORT_IC = 1'b0,
    PORT_DC = 1'b1
  } port_id_e;

  // Grant vector bit 0 is the instruction side, bit 1 the data side.
  function automatic port_id_e port_of_grant(input logic [1:0] gnt);
    return gnt[1] ? PORT_DC : PORT_IC;
  endfunction

endpackage

// File: rtl/axi4_lite_fill_arbiter_if.sv
// Bundle of the two fill requesters and the single-beat read master link.
interface axi4_lite_fill_arbiter_if #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int WORDS_PER_LINE = 16
);
  localparam int LINE_W = WORDS_PER_LINE * AXI_DATA_WIDTH;

  logic                      ic_req_i;
  logic [AXI_ADDR_WIDTH-1:0] ic_addr_i;
  logic [LINE_W-1:0]         ic_line_o;
  logic                      ic_fault_o;
  logic                      ic_done_o;

  logic                      dc_req_i;
  logic [AXI_ADDR_WIDTH-1:0] dc_addr_i;
  logic [LINE_W-1:0]         dc_line_o;
  logic                      dc_fault_o;
  logic                      dc_done_o;

  logic [AXI_ADDR_WIDTH-1:0] mst_addr_o;
  logic                      mst_start_read_o;
  logic [AXI_DATA_WIDTH-1:0] mst_data_i;
  logic                      mst_access_fault_i;
  logic                      mst_done_i;

  // Arbiter view.
  modport slave (
    input  ic_req_i, ic_addr_i, dc_req_i, dc_addr_i,
    input  mst_data_i, mst_access_fault_i, mst_done_i,
    output ic_line_o, ic_fault_o, ic_done_o,
    output dc_line_o, dc_fault_o, dc_done_o,
    output mst_addr_o, mst_start_read_o
  );

  // Environment view: requesters plus read master.
  modport master (
    output ic_req_i, ic_addr_i, dc_req_i, dc_addr_i,
    output mst_data_i, mst_access_fault_i, mst_done_i,
    input  ic_line_o, ic_fault_o, ic_done_o,
    input  dc_line_o, dc_fault_o, dc_done_o,
    input  mst_addr_o, mst_start_read_o
  );
endinterface

// File: rtl/axi4_lite_fill_arbiter_rr_arbiter2.sv
// Two-way round-robin selector; the last winner loses the next tie.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_dc_q;

  // One-hot grant, only while enabled.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_dc_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // Remember who won; reset to data side so instruction side wins first tie.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      last_dc_q <= 1'b1;
    end else if (en_i && (|req_i)) begin
      last_dc_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/axi4_lite_fill_arbiter.sv
// Line-fill arbiter: picks one of two requesters and fetches a full line
// beat by beat through a single-beat read master.
module axi4_lite_fill_arbiter
  import axi4_lite_fill_arbiter_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int WORDS_PER_LINE = 16
) (
  input logic                    clk_i,
  input logic                    arst_i,
  axi4_lite_fill_arbiter_if.slave bus
);

  localparam int BYTES     = AXI_DATA_WIDTH / 8;
  localparam int BYTE_BITS = $clog2(BYTES);
  localparam int LINE_W    = WORDS_PER_LINE * AXI_DATA_WIDTH;
  localparam int OFFS_BITS = $clog2(LINE_W / 8);
  localparam int CNT_W     = $clog2(WORDS_PER_LINE);
  localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK =
    ~((AXI_ADDR_WIDTH'(1) << OFFS_BITS) - AXI_ADDR_WIDTH'(1));

  fill_state_e               state_q, state_d;
  port_id_e                  port_q;
  logic [AXI_ADDR_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [LINE_W-1:0]         line_q;
  logic                      fault_q;

  logic [1:0]                gnt;
  port_id_e                  grant_port;
  logic [AXI_ADDR_WIDTH-1:0] grant_addr;
  logic [AXI_ADDR_WIDTH-1:0] beat_off;
  logic                      beat_last;
  logic                      start_w;
  logic                      done_w;

  rr_arbiter2 u_rr (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .en_i   (state_q == ST_IDLE),
    .req_i  ({bus.dc_req_i, bus.ic_req_i}),
    .gnt_o  (gnt)
  );

  assign grant_port = port_of_grant(gnt);
  assign grant_addr = (grant_port == PORT_DC) ? bus.dc_addr_i : bus.ic_addr_i;
  assign beat_off   = AXI_ADDR_WIDTH'(cnt_q) << BYTE_BITS;
  assign beat_last  = (cnt_q == CNT_W'(WORDS_PER_LINE - 1));

  // State register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_d = state_q;
    start_w = 1'b0;
    done_w  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (|gnt) state_d = ST_ISSUE;
      ST_ISSUE: begin
        start_w = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT:  if (bus.mst_done_i) begin
        state_d = (bus.mst_access_fault_i || beat_last) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE:  begin
        done_w  = 1'b1;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Fill context: latched on grant, updated on each returned beat.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      port_q  <= PORT_IC;
      base_q  <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && (|gnt)) begin
        port_q  <= grant_port;
        base_q  <= grant_addr & LINE_MASK;
        cnt_q   <= '0;
        line_q  <= '0;
        fault_q <= 1'b0;
      end else if (state_q == ST_WAIT && bus.mst_done_i) begin
        line_q[int'(cnt_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= bus.mst_data_i;
        if (bus.mst_access_fault_i) fault_q <= 1'b1;
        else if (!beat_last)        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.mst_start_read_o = start_w;
  assign bus.mst_addr_o       = (state_q == ST_ISSUE || state_q == ST_WAIT) ?
                                (base_q + beat_off) : '0;

  assign bus.ic_done_o  = done_w && (port_q == PORT_IC);
  assign bus.dc_done_o  = done_w && (port_q == PORT_DC);
  assign bus.ic_fault_o = bus.ic_done_o && fault_q;
  assign bus.dc_fault_o = bus.dc_done_o && fault_q;
  assign bus.ic_line_o  = line_q;
  assign bus.dc_line_o  = line_q;

endmodule

// File: tb/tb_axi4_lite_fill_arbiter.sv
// Bench for the line-fill arbiter: 4-word lines, 32-bit beats, master
// model answering every beat two cycles after its start pulse.
module tb_axi4_lite_fill_arbiter;

  localparam int AW  = 64;
  localparam int DW  = 32;
  localparam int WPL = 4;

  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_fill_arbiter_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .WORDS_PER_LINE(WPL)) bus ();

  axi4_lite_fill_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .WORDS_PER_LINE(WPL)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Read master model: data word = (0xA0 + beat index) ^ data_xor.
  logic        m_busy, m_done;
  logic [63:0] m_addr;
  int          fault_beat = -1;
  logic [31:0] data_xor   = '0;
  logic        stray_done = 1'b0;
  logic [63:0] start_q[$];

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_addr <= '0;
    end else begin
      m_done <= 1'b0;
      if (bus.mst_start_read_o) begin
        start_q.push_back(bus.mst_addr_o);
        m_busy <= 1'b1;
        m_addr <= bus.mst_addr_o;
      end else if (m_busy) begin
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end
    end
  end

  assign bus.mst_done_i         = m_done | stray_done;
  assign bus.mst_data_i         = m_done ? ((32'hA0 + {30'd0, m_addr[3:2]}) ^ data_xor) : 32'h0;
  assign bus.mst_access_fault_i = m_done && (fault_beat == int'(m_addr[3:2]));

  // Done monitor.
  int          ic_done_n = 0, dc_done_n = 0, both_done_n = 0;
  int          cap_port;
  logic        cap_fault;
  logic [127:0] cap_line, cap_other_line;

  always @(negedge clk) begin
    if (bus.ic_done_o) begin
      ic_done_n++;
      cap_port = 0; cap_fault = bus.ic_fault_o; cap_line = bus.ic_line_o; cap_other_line = bus.dc_line_o;
    end
    if (bus.dc_done_o) begin
      dc_done_n++;
      cap_port = 1; cap_fault = bus.dc_fault_o; cap_line = bus.dc_line_o; cap_other_line = bus.ic_line_o;
    end
    if (bus.ic_done_o && bus.dc_done_o) both_done_n++;
  end

  // Reference model, from the fill rules.
  function automatic int model_beats(input int fb);
    return (fb >= 0 && fb < WPL) ? fb + 1 : WPL;
  endfunction

  function automatic logic [127:0] model_line(input int fb, input logic [31:0] x);
    logic [127:0] l = '0;
    for (int i = 0; i < model_beats(fb); i++) l[i*32 +: 32] = (32'hA0 + i) ^ x;
    return l;
  endfunction

  task automatic set_req(input int port, input logic v);
    if (port == 0) bus.ic_req_i = v;
    else           bus.dc_req_i = v;
  endtask

  task automatic run_fill(input int port, input logic [63:0] addr, input int fb, input logic [31:0] x,
                          input bit drop, input logic [63:0] exp_base, input int exp_starts,
                          input logic exp_fault, input logic [127:0] exp_line, input string nm);
    int cyc;
    bit seen = 0;
    fault_beat = fb; data_xor = x;
    start_q.delete(); ic_done_n = 0; dc_done_n = 0; both_done_n = 0;
    @(negedge clk);
    if (port == 0) bus.ic_addr_i = addr; else bus.dc_addr_i = addr;
    set_req(port, 1'b1);
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk); #1;
      if (drop && start_q.size() >= 2) set_req(port, 1'b0);
      if (ic_done_n + dc_done_n > 0) begin seen = 1; break; end
    end
    set_req(port, 1'b0);
    if (!seen) begin
      chk({nm, " timeout"}, 1, 0);
      return;
    end
    chk({nm, " latency"}, cyc, 1 + 3 * exp_starts);
    chk({nm, " port"}, cap_port, port);
    chk({nm, " fault"}, cap_fault, exp_fault);
    chk({nm, " line"}, cap_line, exp_line);
    chk({nm, " line both ports"}, cap_other_line, exp_line);
    chk({nm, " starts"}, start_q.size(), exp_starts);
    for (int i = 0; i < exp_starts && i < start_q.size(); i++)
      chk($sformatf("%s start%0d addr", nm, i), start_q[i], exp_base + 64'(4 * i));
    repeat (3) @(negedge clk);
    #1;
    chk({nm, " ic pulses"}, ic_done_n, (port == 0) ? 1 : 0);
    chk({nm, " dc pulses"}, dc_done_n, (port == 1) ? 1 : 0);
    chk({nm, " line hold"}, bus.ic_line_o, exp_line);
  endtask

  task automatic wait_any_done(output int port, output bit ok);
    int base_n = ic_done_n + dc_done_n;
    ok = 0; port = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (ic_done_n + dc_done_n > base_n) begin ok = 1; port = cap_port; return; end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); arst = 1'b1;
    @(negedge clk); @(negedge clk); arst = 1'b0;
  endtask

  typedef struct {
    int           port;
    logic [63:0]  addr;
    int           fb;
    logic [31:0]  xr;
    bit           drop;
    logic [63:0]  exp_base;
    int           exp_starts;
    logic         exp_fault;
    logic [127:0] exp_line;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int   p, order[4];
    bit   ok;
    int   fb;
    logic [63:0] a;
    logic [31:0] x;
    logic [127:0] held;

    vecs[0] = '{0, 64'h1004, -1, 32'h0, 0, 64'h1000, 4, 1'b0, 128'h000000A3_000000A2_000000A1_000000A0};
    vecs[1] = '{1, 64'h2000,  1, 32'h0, 0, 64'h2000, 2, 1'b1, 128'h00000000_00000000_000000A1_000000A0};
    vecs[2] = '{1, 64'h300C, -1, 32'h0, 1, 64'h3000, 4, 1'b0, 128'h000000A3_000000A2_000000A1_000000A0};
    vecs[3] = '{0, 64'hFFFF_FFFF_FFFF_FFFC, 3, 32'h0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 4, 1'b1,
                128'h000000A3_000000A2_000000A1_000000A0};
    vecs[4] = '{1, 64'h17, 0, 32'h0, 0, 64'h10, 1, 1'b1, 128'h00000000_00000000_00000000_000000A0};
    vecs[5] = '{0, 64'h8000_0000_1234_567B, -1, 32'hDEAD0000, 0, 64'h8000_0000_1234_5670, 4, 1'b0,
                128'hDEAD00A3_DEAD00A2_DEAD00A1_DEAD00A0};

    bus.ic_req_i = 0; bus.dc_req_i = 0; bus.ic_addr_i = '0; bus.dc_addr_i = '0;
    #2 arst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset ic_done", bus.ic_done_o, 0);
    chk("reset dc_done", bus.dc_done_o, 0);
    chk("reset faults", {bus.ic_fault_o, bus.dc_fault_o}, 0);
    chk("reset line", bus.ic_line_o, 0);
    chk("reset start", bus.mst_start_read_o, 0);
    chk("reset addr", bus.mst_addr_o, 0);
    @(negedge clk); arst = 1'b0;

    // Tie right after reset, then sustained tie: IC, DC, IC, DC.
    @(negedge clk);
    bus.ic_addr_i = 64'h100; bus.dc_addr_i = 64'h200;
    fault_beat = -1; data_xor = '0;
    bus.ic_req_i = 1; bus.dc_req_i = 1;
    for (int k = 0; k < 4; k++) begin
      wait_any_done(p, ok);
      if (!ok) chk($sformatf("tie done%0d timeout", k), 1, 0);
      order[k] = p;
    end
    bus.ic_req_i = 0; bus.dc_req_i = 0;
    chk("tie order0", order[0], 0);
    chk("tie order1", order[1], 1);
    chk("tie order2", order[2], 0);
    chk("tie order3", order[3], 1);
    chk("tie single done", both_done_n, 0);
    repeat (3) @(negedge clk);

    // Directed table.
    for (int i = 0; i < 6; i++)
      run_fill(vecs[i].port, vecs[i].addr, vecs[i].fb, vecs[i].xr, vecs[i].drop,
               vecs[i].exp_base, vecs[i].exp_starts, vecs[i].exp_fault, vecs[i].exp_line,
               $sformatf("vec%0d", i));

    // Stray beat-done while idle must be ignored.
    held = bus.ic_line_o;
    start_q.delete(); ic_done_n = 0; dc_done_n = 0;
    @(negedge clk); stray_done = 1'b1;
    @(negedge clk); stray_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("stray starts", start_q.size(), 0);
    chk("stray dones", ic_done_n + dc_done_n, 0);
    chk("stray line", bus.ic_line_o, held);
    chk("stray addr", bus.mst_addr_o, 0);
    run_fill(1, 64'h6000, -1, 32'h11, 0, 64'h6000, 4, 1'b0, model_line(-1, 32'h11), "after stray");

    // Reset during the wait of the second beat.
    fault_beat = -1; data_xor = '0;
    start_q.delete(); ic_done_n = 0; dc_done_n = 0;
    @(negedge clk);
    bus.ic_addr_i = 64'h4000; bus.ic_req_i = 1;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (start_q.size() == 2) begin ok = 1; break; end
    end
    if (!ok) chk("midreset second beat timeout", 1, 0);
    arst = 1'b1; bus.ic_req_i = 0;
    #1;
    chk("midreset done", {bus.ic_done_o, bus.dc_done_o}, 0);
    chk("midreset line", bus.ic_line_o, 0);
    chk("midreset addr", bus.mst_addr_o, 0);
    chk("midreset start", bus.mst_start_read_o, 0);
    @(negedge clk); arst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("midreset no done", ic_done_n + dc_done_n, 0);
    chk("midreset no beats", start_q.size(), 2);
    run_fill(0, 64'h5008, -1, 32'h0, 0, 64'h5000, 4, 1'b0, model_line(-1, 32'h0), "after reset");

    // Randomized fills against the model.
    for (int r = 0; r < 16; r++) begin
      int rr = $urandom_range(0, 7);
      p  = $urandom_range(0, 1);
      a  = {$urandom, $urandom};
      x  = $urandom;
      fb = (rr < 4) ? rr : -1;
      run_fill(p, a, fb, x, bit'($urandom_range(0, 1)), a - (a % 64'd16), model_beats(fb),
               (fb >= 0), model_line(fb, x), $sformatf("rand%0d", r));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_fill_arbiter.md
AXI4_LITE_FILL_ARBITER -- requirements
Module: axi4_lite_fill_arbiter

Interface
REQ-001 The block SHALL have parameter AXI_ADDR_WIDTH, default 64: byte address width.
REQ-002 The block SHALL have parameter AXI_DATA_WIDTH, default 32: beat width in bits.
REQ-003 The block SHALL have parameter WORDS_PER_LINE, default 16, a power of two ≥2: number of beats per line fill.
REQ-004 Ports (name dir width meaning), clock and reset first; reset arst_i is asynchronous and active-high; clock is clk_i:
  clk_i  in  1  clock
  arst_i  in  1  asynchronous active-high reset
  ic_req_i  in  1  instruction-side fill request, level, held until ic_done_o
  ic_addr_i  in  AXI_ADDR_WIDTH  instruction-side fill address, stable while ic_req_i=1
  ic_line_o  out  WORDS_PER_LINE*AXI_DATA_WIDTH  filled line, word 0 in LSBs
  ic_fault_o  out  1  fill faulted, valid with ic_done_o
  ic_done_o  out  1  one-cycle fill-complete pulse
  dc_req_i / dc_addr_i / dc_line_o / dc_fault_o / dc_done_o  same widths and meanings, data side
  mst_addr_o  out  AXI_ADDR_WIDTH  beat address to the AXI4-Lite read master
  mst_start_read_o  out  1  one-cycle beat-start pulse to the master
  mst_data_i  in  AXI_DATA_WIDTH  beat data from the master
  mst_access_fault_i  in  1  beat fault, sampled only with mst_done_i
  mst_done_i  in  1  one-cycle beat-complete pulse from the master

Function
REQ-005 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-006 IDLE: no request -> stay; one request -> grant it; both -> grant the port not granted last (round-robin). On grant: latch the port id, latch the base address = requested address with its low log2(WORDS_PER_LINE*AXI_DATA_WIDTH/8) bits forced to 0, clear the beat counter, clear the line buffer, clear the fault flag, then go to ISSUE.
REQ-007 ISSUE SHALL last exactly one cycle with mst_start_read_o=1 and mst_addr_o = base + counter*(AXI_DATA_WIDTH/8), then go to WAIT.
REQ-008 WAIT SHALL hold mst_start_read_o=0 and mst_addr_o stable until mst_done_i=1; mst_done_i SHALL be ignored in every other state.
REQ-009 On mst_done_i in WAIT: store mst_data_i in line word[counter]; if mst_access_fault_i=1 -> set fault, go to DONE; else if counter==WORDS_PER_LINE-1 -> go to DONE; else increment counter, go to ISSUE.
REQ-010 DONE SHALL last one cycle, pulse the granted port's done_o and drive its fault_o from the fault flag, then go to IDLE; the other port's done_o SHALL stay 0.
REQ-011 On fault, no further beats SHALL be issued; words after the faulting beat SHALL read 0.
REQ-012 ic_line_o and dc_line_o SHALL both present the line buffer, which holds its value until the next grant.
REQ-013 Fault-free fill latency, grant cycle to done pulse, SHALL be 1 + Σ(1 + master beat latency) cycles; no idle cycle between a beat done and the next ISSUE.
REQ-014 A request deasserted mid-fill SHALL NOT abort the fill; done SHALL still pulse.
REQ-015 A request still asserted in the DONE cycle SHALL NOT be regranted in that cycle; arbitration restarts in IDLE the next cycle.
REQ-016 Address arithmetic SHALL wrap modulo 2^AXI_ADDR_WIDTH; the counter width SHALL be log2(WORDS_PER_LINE).

Reset
REQ-017 While arst_i=1: state=IDLE, all outputs 0, line buffer 0, counter 0, fault 0, last-granted=data side, so the instruction side wins the first tie.
REQ-018 Reset asserted mid-fill SHALL abandon the fill with no done pulse; the master SHALL be reset by the same arst_i.

Structure
REQ-019 The FSM state enum and the port-id typedef (PORT_IC, PORT_DC) SHALL reside in the shared package.
REQ-020 The round-robin selector SHALL be a sub-module rr_arbiter2 (two requests, last-grant register, enable input, one-hot grant).

Verification (bench: WORDS_PER_LINE=4, AXI_DATA_WIDTH=32, master model with 2-cycle beat latency)
REQ-021 ic_req_i=1, ic_addr_i=0x1004 -> beats at 0x1000, 0x1004, 0x1008, 0x100C with returned data 0xA0..0xA3 -> ic_line_o=0x000000A3_000000A2_000000A1_000000A0, ic_fault_o=0, one ic_done_o pulse, dc_done_o=0.
REQ-022 ic_req_i and dc_req_i raised in the same cycle after reset -> IC filled first, then DC; repeat with both asserted -> grant order alternates IC, DC, IC, DC.
REQ-023 dc fill at 0x2000 with fault on beat 1 -> only 2 start pulses, dc_fault_o=1 with dc_done_o, words 2 and 3 = 0.
REQ-024 arst_i pulsed during WAIT of beat 2 -> all outputs 0 next cycle, no done pulse, and a subsequent ic request completes normally.
REQ-025 dc_req_i dropped after the first beat -> all 4 beats issued and dc_done_o pulses once; a stray mst_done_i in IDLE -> no state change.
